// File: rtl/inst_mem_loader_pkg.sv
// inst_loader_pkg: shared widths, FSM state encoding and instruction types
// for the instruction-memory loader.
// Optional build macro: CHECKSUM_EN (enables the trailing XOR check byte).
package inst_loader_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int INST_W_DEF = 9;

  typedef logic [8:0] inst_t;
  typedef logic [9:0] iaddr_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_LO    = 3'd3,
    S_HI    = 3'd4,
    S_WRITE = 3'd5,
    S_CHK   = 3'd6,
    S_DONE  = 3'd7
  } loader_state_e;

  // Instruction bit 8 lives in bit 0 of the HI byte; the rest of HI is ignored.
  function automatic inst_t pack_inst(input logic hi_bit0, input logic [7:0] lo);
    return {hi_bit0, lo};
  endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: byte-stream input, instruction-memory write port and
// CPU hold/status lines of the loader.
// master = host/byte source side, slave = loader side.
// Optional build macro: CHECKSUM_EN (Error is only meaningful when defined).
interface inst_mem_loader_if
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
);

  logic              Start;
  logic [7:0]        ByteIn;
  logic              ByteValid;
  logic              ByteReady;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [INST_W-1:0] WrData;
  logic              CpuHold;
  logic              Done;
  logic              Error;

  modport master (
    output Start, ByteIn, ByteValid,
    input  ByteReady, WrEn, WrAddr, WrData, CpuHold, Done, Error
  );

  modport slave (
    input  Start, ByteIn, ByteValid,
    output ByteReady, WrEn, WrAddr, WrData, CpuHold, Done, Error
  );

endinterface

// File: rtl/inst_mem_loader_cksum.sv
// loader_cksum: 8-bit XOR accumulator over accepted stream bytes, with a
// compare output used to judge the trailing check byte.
// Only built when CHECKSUM_EN is defined; otherwise this file is empty.
`ifdef CHECKSUM_EN
module loader_cksum (
  input  logic       clk,
  input  logic       srst,
  input  logic       clr,
  input  logic       acc_en,
  input  logic [7:0] byte_in,
  output logic       match
);

  logic [7:0] acc_reg;

  // Clear has priority; it only coincides with idle/done where no byte is accepted.
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      acc_reg <= '0;
    end else if (acc_en) begin
      acc_reg <= acc_reg ^ byte_in;
    end
  end

  assign match = (byte_in == acc_reg);

endmodule
`endif

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: receives a program as a byte stream (2 header bytes with
// count = N-1, then N LO/HI byte pairs) and writes 9-bit instructions to the
// instruction memory at addresses 0..N-1, holding the CPU until finished.
// Optional build macro: CHECKSUM_EN adds a trailing XOR check byte and Error.
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input logic             Clk,
  input logic             Reset,
  inst_mem_loader_if.slave bus
);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_HDR0  = S_HDR0;
  localparam logic [2:0] ST_HDR1  = S_HDR1;
  localparam logic [2:0] ST_LO    = S_LO;
  localparam logic [2:0] ST_HI    = S_HI;
  localparam logic [2:0] ST_WRITE = S_WRITE;
  localparam logic [2:0] ST_CHK   = S_CHK;
  localparam logic [2:0] ST_DONE  = S_DONE;

`ifdef CHECKSUM_EN
  localparam logic [2:0] ST_AFTER_LAST = ST_CHK;
`else
  localparam logic [2:0] ST_AFTER_LAST = ST_DONE;
`endif

  logic [2:0]        state_reg;
  logic [2:0]        state_next;
  iaddr_t            count_reg;
  logic [7:0]        lo_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [INST_W-1:0] wr_data_reg;

  logic byte_ready;
  logic byte_fire;
  logic start_ok;
  logic last_write;
  logic error_bit;

  assign byte_ready = (state_reg == ST_HDR0) || (state_reg == ST_HDR1) ||
                      (state_reg == ST_LO)   || (state_reg == ST_HI)   ||
                      (state_reg == ST_CHK);
  assign byte_fire  = bus.ByteValid && byte_ready;
  assign start_ok   = bus.Start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  // Termination is by count, so the address counter never needs to wrap.
  assign last_write = (addr_reg == ADDR_W'(count_reg));

  // Next-state selection; bytes only advance the receiving states.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_ok)  state_next = ST_HDR0;
      ST_HDR0:  if (byte_fire) state_next = ST_HDR1;
      ST_HDR1:  if (byte_fire) state_next = ST_LO;
      ST_LO:    if (byte_fire) state_next = ST_HI;
      ST_HI:    if (byte_fire) state_next = ST_WRITE;
      ST_WRITE: state_next = last_write ? ST_AFTER_LAST : ST_LO;
      ST_CHK:   if (byte_fire) state_next = ST_DONE;
      ST_DONE:  if (start_ok)  state_next = ST_HDR0;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Header capture, byte-pair assembly, write-port registers and address counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_reg   <= '0;
      lo_reg      <= '0;
      addr_reg    <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      if (start_ok) begin
        addr_reg <= '0;
      end else if ((state_reg == ST_WRITE) && !last_write) begin
        addr_reg <= addr_reg + ADDR_W'(1);
      end
      if (byte_fire) begin
        case (state_reg)
          ST_HDR0: count_reg[7:0] <= bus.ByteIn;
          ST_HDR1: count_reg[9:8] <= bus.ByteIn[1:0];
          ST_LO:   lo_reg         <= bus.ByteIn;
          ST_HI: begin
            // Loaded one cycle early so WrAddr/WrData are valid throughout WRITE
            // and then simply hold until the next instruction.
            wr_addr_reg <= addr_reg;
            wr_data_reg <= INST_W'(pack_inst(bus.ByteIn[0], lo_reg));
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CHECKSUM_EN
  logic cksum_match;
  logic error_reg;

  loader_cksum u_cksum (
    .clk     (Clk),
    .srst    (Reset),
    .clr     (start_ok),
    .acc_en  (byte_fire && (state_reg != ST_CHK)),
    .byte_in (bus.ByteIn),
    .match   (cksum_match)
  );

  // Error is set by a bad check byte and held until the next Start or Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      error_reg <= 1'b0;
    end else if (start_ok) begin
      error_reg <= 1'b0;
    end else if ((state_reg == ST_CHK) && byte_fire) begin
      error_reg <= !cksum_match;
    end
  end

  assign error_bit = error_reg;
`else
  assign error_bit = 1'b0;
`endif

  assign bus.ByteReady = byte_ready;
  assign bus.WrEn      = (state_reg == ST_WRITE);
  assign bus.WrAddr    = wr_addr_reg;
  assign bus.WrData    = wr_data_reg;
  assign bus.Done      = (state_reg == ST_DONE);
  assign bus.Error     = error_bit;
  // The CPU is released only after a clean finish.
  assign bus.CpuHold   = !((state_reg == ST_DONE) && !error_bit);

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: randomized byte-stream loads checked against a program
// model (expected write N = prog[N] at address N, N = 0..count).
// Optional build macro: CHECKSUM_EN (appends and checks the XOR byte).
module tb_inst_mem_loader;
  import inst_loader_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  inst_mem_loader_if #(.ADDR_W(10), .INST_W(9)) bus ();

  inst_mem_loader #(.ADDR_W(10), .INST_W(9)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] stream_q[$];
  logic [8:0] prog[1024];
  logic [8:0] tb_mem[1024];
  logic [9:0] obs_addr_q[$];
  logic [8:0] obs_data_q[$];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Instruction memory model plus write log.
  always @(negedge Clk) begin
    if (bus.WrEn === 1'b1) begin
      obs_addr_q.push_back(bus.WrAddr);
      obs_data_q.push_back(bus.WrData);
      tb_mem[bus.WrAddr] = bus.WrData;
      $display("write addr=%0d data=%03h", bus.WrAddr, bus.WrData);
      check("ready_low_in_write", 32'(bus.ByteReady), 0);
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(bus.ByteReady), 0);
    check({tag, "_wren"},  32'(bus.WrEn), 0);
    check({tag, "_waddr"}, 32'(bus.WrAddr), 0);
    check({tag, "_wdata"}, 32'(bus.WrData), 0);
    check({tag, "_hold"},  32'(bus.CpuHold), 1);
    check({tag, "_done"},  32'(bus.Done), 0);
    check({tag, "_error"}, 32'(bus.Error), 0);
  endtask

  // Build the byte stream for prog[0..n-1]; ignored bits get random values.
  task automatic build_stream(input int n);
    logic [9:0] cnt;
    cnt = 10'(n - 1);
    stream_q = {};
    stream_q.push_back(cnt[7:0]);
    stream_q.push_back({6'($urandom), cnt[9:8]});
    for (int i = 0; i < n; i++) begin
      stream_q.push_back(prog[i][7:0]);
      stream_q.push_back({7'($urandom), prog[i][8]});
    end
  endtask

  // Called at a negedge; returns at the negedge after the last accepted byte.
  task automatic send_stream(input int limit, input bit gaps, input bit stray);
    for (int i = 0; i < limit; i++) begin
      bit acc;
      int waited;
      acc = 1'b0;
      waited = 0;
      while (!acc) begin
        bus.ByteIn    = stream_q[i];
        bus.ByteValid = (gaps && ($urandom_range(0, 2) == 0)) ? 1'b0 : 1'b1;
        bus.Start     = stray && ($urandom_range(0, 7) == 0);
        acc = bus.ByteValid && bus.ByteReady;
        @(negedge Clk);
        waited++;
        if (!acc && waited > 200) begin
          check("byte_accept_timeout", 0, 1);
          bus.ByteValid = 1'b0;
          bus.Start = 1'b0;
          return;
        end
      end
    end
    bus.ByteValid = 1'b0;
    bus.Start = 1'b0;
  endtask

  task automatic do_load(input int n, input bit gaps, input bit stray,
                         input bit combined, input bit bad_ck);
    logic [7:0] ck;
    bit exp_err;
    ck = 8'h00;
    exp_err = 1'b0;
    foreach (stream_q[i]) ck ^= stream_q[i];
`ifdef CHECKSUM_EN
    if (bad_ck) ck ^= 8'($urandom_range(1, 255));
    exp_err = bad_ck;
    stream_q.push_back(ck);
`else
    if (bad_ck || (ck == 8'h00 && n < 0)) exp_err = 1'b0;
`endif
    obs_addr_q = {};
    obs_data_q = {};
    bus.Start = 1'b1;
    if (combined) begin
      bus.ByteValid = 1'b1;
      bus.ByteIn = stream_q[0];
    end
    check("ready_low_at_start", 32'(bus.ByteReady), 0);
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.ByteValid = 1'b0;
    check("start_done_clr", 32'(bus.Done), 0);
    check("start_hold", 32'(bus.CpuHold), 1);
    check("start_error_clr", 32'(bus.Error), 0);
    check("start_ready", 32'(bus.ByteReady), 1);
    check("start_no_write", 32'(obs_addr_q.size()), 0);
    send_stream(stream_q.size(), gaps, stray);
    for (int c = 0; c < 20 && bus.Done !== 1'b1; c++) @(negedge Clk);
    repeat (3) @(negedge Clk);
    check("load_done", 32'(bus.Done), 1);
    check("load_error", 32'(bus.Error), 32'(exp_err));
    check("load_hold", 32'(bus.CpuHold), 32'(exp_err));
    check("load_wr_count", 32'(obs_addr_q.size()), 32'(n));
    for (int i = 0; i < n && i < obs_addr_q.size(); i++) begin
      check("wr_addr", 32'(obs_addr_q[i]), 32'(i));
      check("wr_data", 32'(obs_data_q[i]), 32'(prog[i]));
    end
    $display("load n=%0d gaps=%0d stray=%0d combined=%0d bad_ck=%0d writes=%0d done=%0d err=%0d",
             n, gaps, stray, combined, bad_ck, obs_addr_q.size(), bus.Done, bus.Error);
  endtask

  initial begin
    int n;
    bus.Start = 1'b0;
    bus.ByteValid = 1'b0;
    bus.ByteIn = 8'h00;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check_reset_values("rst");
    Reset = 1'b0;
    @(negedge Clk);
    check("idle_ready", 32'(bus.ByteReady), 0);
    check("idle_hold", 32'(bus.CpuHold), 1);

    // Basic single-instruction load.
    prog[0] = 9'h1FF;
    stream_q = {8'h00, 8'h00, 8'hFF, 8'h01};
    do_load(1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Three instructions with ignored bits set; Start arrives with ByteValid.
    prog[0] = 9'h012;
    prog[1] = 9'h134;
    prog[2] = 9'h056;
    stream_q = {8'h02, 8'hFC, 8'h12, 8'hFE, 8'h34, 8'h01, 8'h56, 8'h00};
    do_load(3, 1'b0, 1'b0, 1'b1, 1'b0);

    // Basic load again under backpressure and stray Start pulses.
    prog[0] = 9'h1FF;
    stream_q = {8'h00, 8'h00, 8'hFF, 8'h01};
    do_load(1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Random programs of random length.
    repeat (4) begin
      n = $urandom_range(1, 48);
      for (int i = 0; i < n; i++) prog[i] = 9'($urandom);
      build_stream(n);
      do_load(n, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Full depth: 1024 instructions, data = address[8:0].
    for (int i = 0; i < 1024; i++) prog[i] = 9'(i);
    build_stream(1024);
    do_load(1024, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1024; i++) check("mem_readback", 32'(tb_mem[i]), 32'(i & 511));

    // Reset after two writes, then a fresh load from address 0.
    for (int i = 0; i < 5; i++) prog[i] = 9'($urandom);
    build_stream(5);
    obs_addr_q = {};
    obs_data_q = {};
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    send_stream(6, 1'b1, 1'b0);
    repeat (3) @(negedge Clk);
    check("midload_writes", 32'(obs_addr_q.size()), 2);
    check("midload_hold", 32'(bus.CpuHold), 1);
    Reset = 1'b1;
    @(negedge Clk);
    check_reset_values("midrst");
    Reset = 1'b0;
    @(negedge Clk);
    n = 20;
    for (int i = 0; i < n; i++) prog[i] = 9'($urandom);
    build_stream(n);
    do_load(n, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef CHECKSUM_EN
    // Wrong check byte, then a good load whose Start clears Error.
    n = 6;
    for (int i = 0; i < n; i++) prog[i] = 9'($urandom);
    build_stream(n);
    do_load(n, 1'b1, 1'b0, 1'b0, 1'b1);
    build_stream(n);
    do_load(n, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer-side counterpart of the instruction memory: receives a program as a byte stream and writes 9-bit instructions into the instruction memory write port at consecutive addresses starting at 0.
- Holds the processor in hold (CpuHold) until the whole program has been written.
- Sits between the host/testbench byte source and the instruction memory.

Parameters:
ADDR_W, 10, instruction address width; memory depth is 2**ADDR_W.
INST_W, 9, instruction width; fixed at 9 by the ISA, and the byte-pair packing depends on it.

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE
ByteIn  input  8  stream data
ByteValid  input  1  ByteIn is valid
ByteReady  output  1  loader can accept a byte; transfer occurs when ByteValid && ByteReady at a rising edge
WrEn  output  1  instruction memory write enable
WrAddr  output  ADDR_W  write address
WrData  output  INST_W  write data
CpuHold  output  1  processor must not fetch while high
Done  output  1  load complete
Error  output  1  checksum mismatch (CHECKSUM_EN only; tied 0 otherwise)

Behaviour:
- Reset values: ByteReady=0, WrEn=0, WrAddr=0, WrData=0, CpuHold=1, Done=0, Error=0, state=IDLE, address counter=0.
- Stream format:
  - HDR0 = count[7:0]; HDR1 bits[1:0] = count[9:8], bits[7:2] ignored.
  - Program length N = count+1, so N ranges 1..1024.
  - Then N pairs: LO = inst[7:0]; HI bit0 = inst[8], bits[7:1] ignored.
- States:
  - IDLE: Start -> HDR0.
  - HDR0: byte accepted -> HDR1.
  - HDR1: byte accepted -> LO.
  - LO: byte accepted -> HI.
  - HI: byte accepted -> WRITE.
  - WRITE, one cycle: WrEn=1, WrAddr=addr counter, WrData={hi[0],lo}.
    - If addr == count: -> DONE (or CHK with CHECKSUM_EN).
    - Else: addr++ and -> LO.
  - DONE: Done=1, CpuHold=0. Start -> HDR0, which clears Done, sets CpuHold=1 and resets addr to 0.
- ByteReady=1 only in HDR0, HDR1, LO, HI (and CHK). It is 0 in IDLE, WRITE and DONE.
- Bytes presented while ByteReady=0 are not consumed; the source holds them.
- Latency: WrEn is high in the cycle immediately after the HI byte is accepted. Minimum of 3 cycles per instruction.
- WrEn is never high outside WRITE. WrAddr and WrData hold their last values otherwise.
- CpuHold=1 in every state except DONE with Error=0.
- Address boundary: N=1024 writes addresses 0..1023. The counter never wraps because termination is by count.
- Start outside IDLE/DONE is ignored. Start and ByteValid arriving together in IDLE: only Start acts, and no byte is consumed that cycle.
- Reset mid-load: immediate return to reset values. Already-written memory locations are not erased.
- ByteValid low stalls in any receiving state indefinitely with no timeout.

Optional Feature:
- Macro CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulator covers every accepted header and instruction byte. It is cleared on Start and on Reset.
  - After the last WRITE -> CHK. CHK accepts one byte.
    - Byte equals accumulator: DONE with Error=0.
    - Otherwise: DONE with Error=1 and CpuHold remains 1.
  - Error is sticky until Start or Reset.
- Undefined: no CHK state, no accumulator, Error tied 0.

Decomposition:
- Package inst_loader_pkg holds:
  - ADDR_W and INST_W defaults.
  - Typedef for the state enum (IDLE, HDR0, HDR1, LO, HI, WRITE, CHK, DONE).
  - Typedefs inst_t (logic[8:0]) and iaddr_t (logic[9:0]).
- Sub-module loader_cksum holds the XOR accumulator (clear, accumulate on byte accept, compare output). Instantiated only under CHECKSUM_EN.
- Everything else is one FSM module.

Test Plan:
- Basic load: Start, then bytes 00,00,FF,01 -> one WrEn pulse with WrAddr=0, WrData=9'h1FF; then Done=1, CpuHold=0.
- Three-instruction load with HI bytes FE/01/00 and ignored bits set -> writes addr0..2 with inst[8] taken only from bit0; exactly 3 WrEn pulses.
- Full depth: count=3FF, 1024 pairs with data=addr[8:0] -> last write at WrAddr=1023, no 1024th write, memory readback matches.
- Backpressure: ByteValid toggled randomly -> ByteReady=0 during WRITE; no byte lost or duplicated; results identical to the basic load.
- Reset mid-load after 2 writes: all outputs return to reset values; a subsequent full load succeeds from addr 0.
- CHECKSUM_EN: correct XOR byte -> Done=1, Error=0, CpuHold=0. Wrong byte -> Done=1, Error=1, CpuHold=1; Error clears on the next Start.
